fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of upstream requesters sharing one sync_fifo write port.
REQ-002 Parameter DW, default 33, beat width; bit DW-1 is the end-of-packet (EOP) flag, bits DW-2:0 payload.
REQ-003 Parameter MAX_BEATS, default 16, maximum beats per grant before forced release.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 nrst  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  N_REQ  per-requester beat valid.
REQ-007 req_data  input  N_REQ*DW  flattened beats, requester i at bits [i*DW +: DW].
REQ-008 req_ready  output  N_REQ  per-requester accept.
REQ-009 out_valid  output  1  to FIFO upstr_d_valid.
REQ-010 out_data  output  DW  to FIFO upstr_data.
REQ-011 out_ready  input  1  from FIFO upstr_d_ready.
REQ-012 grant_id  output  clog2(N_REQ)  index of current owner; valid only while busy=1.
REQ-013 busy  output  1  high in GRANT state.

Function
REQ-014 Two states, IDLE and GRANT.
REQ-015 IDLE: out_valid=0, req_ready=0; if any req_valid is set, select the first set bit searching cyclically from last_grant+1, register it into grant_id, clear beat_cnt, enter GRANT next cycle (one-cycle arbitration latency).
REQ-016 IDLE with no req_valid set: remain IDLE, grant_id and last_grant unchanged.
REQ-017 GRANT: out_valid=req_valid[grant_id], out_data=req_data slice grant_id, req_ready[grant_id]=out_ready, all other req_ready=0; pass-through is combinational, with no added latency.
REQ-018 A transfer occurs when out_valid and out_ready are both 1; each transfer increments beat_cnt (width clog2(MAX_BEATS+1)).
REQ-019 Transfer with EOP=1: next state IDLE, last_grant<=grant_id.
REQ-020 Transfer with EOP=0 that brings beat_cnt to MAX_BEATS: forced release, next state IDLE, last_grant<=grant_id; the next grant takes no account of packet boundaries.
REQ-021 Owner deasserts req_valid mid-packet: grant is held indefinitely, with no timeout.
REQ-022 out_ready=0 (FIFO full): state, beat_cnt and grant_id are held, and out_data stays stable while out_valid=1 because the requester holds its data.
REQ-023 Because of the IDLE bubble, a single continuously-requesting source sees exactly one dead cycle between grants.
REQ-024 Fairness: with all N_REQ requesting single-beat packets, grants rotate 0,1,...,N_REQ-1,0 in strict order.

Reset
REQ-025 On nrst=0: state=IDLE, last_grant=N_REQ-1 (so requester 0 has first priority), grant_id=0, beat_cnt=0, busy=0, out_valid=0, req_ready=0.
REQ-026 Reset asserted mid-packet aborts the grant immediately, without completing the packet; after release the block resumes from the REQ-025 state.

Structure
REQ-027 Package fifo_arb_pkg holds the state enum (IDLE, GRANT) and default constants N_REQ, DW and MAX_BEATS.
REQ-028 Sub-module rr_pick is a combinational round-robin selector with inputs req vector and last index, and outputs one-hot/index plus any_req; it contains no state.

Verification
REQ-029 Reset release with req_valid=4'b1111 and single-beat EOP packets -> grants in order 0,1,2,3,0; one idle cycle between each; out_data equals the source beat.
REQ-030 Req 2 sends a 5-beat packet (EOP on beat 5) while req 0 and req 1 are requesting -> req 2 holds the grant for 5 transfers; the next grant goes to 3 if requesting, else 0.
REQ-031 Req 1 sends 20 beats with EOP=0 -> forced release after the 16th transfer; busy=0 for one cycle; req 1 is regranted only after the other active requesters.
REQ-032 out_ready held 0 for 10 cycles mid-packet -> no req_ready, beat_cnt frozen, out_data stable; resumes without loss or duplication.
REQ-033 nrst pulsed low during beat 3 of a packet -> outputs go to reset values asynchronously; the first grant after release goes to requester 0 if it is requesting.
REQ-034 Arbiter connected to sync_fifo with depth 1023 and the downstream port stalled -> when the FIFO is full, out_ready=0 stalls the owner; no beats are dropped; end-to-end scoreboard matches.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int N_REQ     = 4;
  localparam int DW        = 33;
  localparam int MAX_BEATS = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request searching
// cyclically from last+1. Holds no state.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx,
  output logic          any_req
);

  // Walk N positions starting just after the previous owner; first hit wins.
  always_comb begin
    int j;
    gnt_oh  = '0;
    gnt_idx = '0;
    any_req = |req;
    j       = 0;
    for (int k = 1; k <= N; k++) begin
      j = int'(last) + k;
      if (j >= N) j = j - N;
      if (req[j] && (gnt_oh == '0)) begin
        gnt_oh[j] = 1'b1;
        gnt_idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter feeding a single sync_fifo write port.
// IDLE spends one cycle picking an owner; GRANT passes the owner's beats
// straight through until EOP or MAX_BEATS transfers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = fifo_arb_pkg::N_REQ,
  parameter int DW        = fifo_arb_pkg::DW,
  parameter int MAX_BEATS = fifo_arb_pkg::MAX_BEATS,
  localparam int GW       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int BW       = $clog2(MAX_BEATS + 1)
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic                out_valid,
  output logic [DW-1:0]       out_data,
  input  logic                out_ready,
  output logic [GW-1:0]       grant_id,
  output logic                busy
);

  arb_state_e        state;
  logic [GW-1:0]     last_grant;
  logic [BW-1:0]     beat_cnt;
  logic [N_REQ-1:0]  pick_oh;
  logic [GW-1:0]     pick_idx;
  logic              any_req;
  logic              xfer;
  logic              eop;
  logic [DW-1:0]     beats [N_REQ];

  // Unpack the flattened requester beats for indexed selection.
  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign beats[i] = req_data[i*DW +: DW];
  end

  rr_pick #(.N(N_REQ), .IW(GW)) u_pick (
    .req     (req_valid),
    .last    (last_grant),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .any_req (any_req)
  );

  assign busy = (state == GRANT);
  assign xfer = out_valid & out_ready;
  assign eop  = out_data[DW-1];

  // Zero-latency pass-through of the owner's handshake while granted.
  always_comb begin
    out_valid = 1'b0;
    out_data  = beats[grant_id];
    req_ready = '0;
    if (busy) begin
      out_valid           = req_valid[grant_id];
      req_ready[grant_id] = out_ready;
    end
  end

  // Grant lifecycle: pick in IDLE, count beats and release in GRANT.
  // Reset leaves last_grant at the top index so requester 0 wins first.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      last_grant <= GW'(N_REQ - 1);
      grant_id   <= '0;
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id <= pick_idx;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          // Owner dropping valid mid-packet simply stalls here; no timeout.
          if (xfer) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (eop || (beat_cnt == BW'(MAX_BEATS - 1))) begin
              state      <= IDLE;
              last_grant <= grant_id;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
